// File: rtl/qsfp_mgmt_ctrl.sv
// Multi-cage QSFP28 sideband manager: pin sync/debounce, per-cage insertion/reset/init FSM,
// single-owner ModSelL decode for the shared IIC controller and sticky per-cage IRQs.
module qsfp_mgmt_ctrl #(
    parameter int PORTS           = 2,
    parameter int DEBOUNCE_CYCLES = 65536,
    parameter int RESET_CYCLES    = 1024,
    parameter int INIT_CYCLES     = 800000,
    localparam int SELW           = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                 clock,
    input  logic                 resetn,
    input  logic [PORTS-1:0]     qsfp_modprsl,
    input  logic [PORTS-1:0]     qsfp_intl,
    output logic [PORTS-1:0]     qsfp_resetl,
    output logic [PORTS-1:0]     qsfp_lpmode,
    output logic [PORTS-1:0]     qsfp_modsell,
    input  logic [PORTS-1:0]     sw_reset,
    input  logic [PORTS-1:0]     sw_lpmode,
    input  logic [SELW-1:0]      iic_sel,
    input  logic                 iic_sel_en,
    input  logic [PORTS-1:0]     irq_clear,
    output logic [2*PORTS-1:0]   port_state,
    output logic [PORTS-1:0]     port_ready,
    output logic [PORTS-1:0]     irq,
    output logic                 irq_any
);

    localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int MAXC = (RESET_CYCLES > INIT_CYCLES) ? RESET_CYCLES : INIT_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [DBW-1:0] DB_LAST    = DBW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  RESET_LOAD = CW'(RESET_CYCLES);
    localparam logic [CW-1:0]  INIT_LOAD  = CW'(INIT_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE    = CW'(1);

    typedef enum logic [1:0] {
        ST_ABSENT = 2'd0,
        ST_RESET  = 2'd1,
        ST_INIT   = 2'd2,
        ST_READY  = 2'd3
    } state_t;

    logic [2*PORTS-1:0] raw_pins;
    logic [2*PORTS-1:0] deb_pins;
    logic [PORTS-1:0]   prs_deb;
    logic [PORTS-1:0]   int_deb;
    logic               irq_any_q;

    // Low half carries ModPrsL, high half IntL; both share the same debounce rule.
    assign raw_pins = {qsfp_intl, qsfp_modprsl};
    assign prs_deb  = deb_pins[PORTS-1:0];
    assign int_deb  = deb_pins[2*PORTS-1:PORTS];

    for (genvar b = 0; b < 2*PORTS; b++) begin : g_debounce
        logic           sync1_q;
        logic           sync2_q;
        logic           deb_q;
        logic [DBW-1:0] cnt_q;

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                sync1_q <= 1'b1;
                sync2_q <= 1'b1;
                deb_q   <= 1'b1;
                cnt_q   <= '0;
            end else begin
                sync1_q <= raw_pins[b];
                sync2_q <= sync1_q;
                if (sync2_q == deb_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == DB_LAST) begin
                    deb_q <= sync2_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + DBW'(1);
                end
            end
        end

        assign deb_pins[b] = deb_q;
    end

    for (genvar p = 0; p < PORTS; p++) begin : g_cage
        state_t        state_q;
        state_t        state_d;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          int_dly_q;
        logic          resetl_q;
        logic          lpmode_q;
        logic          modsell_q;
        logic          irq_q;
        logic          resetl_d;
        logic          lpmode_d;
        logic          modsell_d;
        logic          irq_set;
        logic          present;
        logic          int_fall;

        assign present  = ~prs_deb[p];
        assign int_fall = int_dly_q & ~int_deb[p];

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                state_q <= ST_ABSENT;
                cnt_q   <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // Removal outranks a software reset; a reset request while absent is dropped.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            if (!present) begin
                state_d = ST_ABSENT;
                cnt_d   = '0;
            end else if (sw_reset[p] && (state_q != ST_ABSENT)) begin
                state_d = ST_RESET;
                cnt_d   = RESET_LOAD;
            end else begin
                case (state_q)
                    ST_ABSENT: begin
                        state_d = ST_RESET;
                        cnt_d   = RESET_LOAD;
                    end
                    ST_RESET: begin
                        if (cnt_q <= CNT_ONE) begin
                            state_d = ST_INIT;
                            cnt_d   = INIT_LOAD;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                    ST_INIT: begin
                        if (cnt_q <= CNT_ONE) begin
                            state_d = ST_READY;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end
                    default: cnt_d = '0;
                endcase
            end
        end

        // Pin outputs are computed from the next state so they move on the same edge as it.
        always_comb begin
            resetl_d  = (state_d == ST_INIT) || (state_d == ST_READY);
            lpmode_d  = (state_d == ST_READY) ? sw_lpmode[p] : 1'b1;
            modsell_d = ~(iic_sel_en && (iic_sel == SELW'(p)) && (state_d == ST_READY));
            irq_set   = (state_q == ST_READY) && (!present || int_fall);
        end

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                int_dly_q <= 1'b1;
                resetl_q  <= 1'b0;
                lpmode_q  <= 1'b1;
                modsell_q <= 1'b1;
                irq_q     <= 1'b0;
            end else begin
                int_dly_q <= int_deb[p];
                resetl_q  <= resetl_d;
                lpmode_q  <= lpmode_d;
                modsell_q <= modsell_d;
                irq_q     <= irq_set | (irq_q & ~irq_clear[p]);
            end
        end

        assign qsfp_resetl[p]       = resetl_q;
        assign qsfp_lpmode[p]       = lpmode_q;
        assign qsfp_modsell[p]      = modsell_q;
        assign irq[p]               = irq_q;
        assign port_state[2*p +: 2] = state_q;
        assign port_ready[p]        = (state_q == ST_READY);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            irq_any_q <= 1'b0;
        end else begin
            irq_any_q <= |irq;
        end
    end

    assign irq_any = irq_any_q;

endmodule

// File: tb/tb_qsfp_mgmt_ctrl.sv
// Bench for qsfp_mgmt_ctrl: directed scenarios plus random pin/software traffic
// compared against a time-based behavioural model of the cage sequencing.
module tb_qsfp_mgmt_ctrl;

  localparam int PORTS = 2;
  localparam int DB    = 4;
  localparam int RC    = 8;
  localparam int IC    = 16;

  logic       clock = 1'b0;
  logic       resetn = 1'b1;
  logic [1:0] modprsl = 2'b11;
  logic [1:0] intl = 2'b11;
  logic [1:0] sw_reset = 2'b00;
  logic [1:0] sw_lpmode = 2'b00;
  logic [1:0] irq_clear = 2'b00;
  logic       iic_sel = 1'b0;
  logic       iic_sel_en = 1'b0;

  logic [1:0] qsfp_resetl;
  logic [1:0] qsfp_lpmode;
  logic [1:0] qsfp_modsell;
  logic [3:0] port_state;
  logic [1:0] port_ready;
  logic [1:0] irq;
  logic       irq_any;

  int errors = 0;
  int checks = 0;

  qsfp_mgmt_ctrl #(
    .PORTS(PORTS),
    .DEBOUNCE_CYCLES(DB),
    .RESET_CYCLES(RC),
    .INIT_CYCLES(IC)
  ) dut (
    .clock(clock),
    .resetn(resetn),
    .qsfp_modprsl(modprsl),
    .qsfp_intl(intl),
    .qsfp_resetl(qsfp_resetl),
    .qsfp_lpmode(qsfp_lpmode),
    .qsfp_modsell(qsfp_modsell),
    .sw_reset(sw_reset),
    .sw_lpmode(sw_lpmode),
    .iic_sel(iic_sel),
    .iic_sel_en(iic_sel_en),
    .irq_clear(irq_clear),
    .port_state(port_state),
    .port_ready(port_ready),
    .irq(irq),
    .irq_any(irq_any)
  );

  always #5 clock = ~clock;

  // ---------------- behavioural reference model ----------------
  // A cage's phase is derived from how long ago its reset pulse started.
  int         m_cyc = 0;
  int         m_t0 [2];
  logic [1:0] m_absent = 2'b11;
  logic [1:0] m_d1_prs = 2'b11, m_d2_prs = 2'b11, m_d1_int = 2'b11, m_d2_int = 2'b11;
  logic [1:0] m_prs = 2'b11, m_int = 2'b11, m_int_old = 2'b11;
  int         m_run_prs [2];
  int         m_run_int [2];
  logic [1:0] m_irq = 2'b00;
  logic       m_irq_any = 1'b0;
  logic [1:0] m_resetl = 2'b00, m_lpmode = 2'b11, m_modsell = 2'b11;
  int         m_old_ph [2];
  int         m_new_ph;
  logic       m_set;
  logic       m_fall;

  function automatic int phase(int p);
    int e;
    if (m_absent[p]) return 0;
    e = m_cyc - m_t0[p];
    if (e < RC) return 1;
    if (e < RC + IC) return 2;
    return 3;
  endfunction

  always begin
    @(posedge clock or negedge resetn);
    if (!resetn) begin
      m_absent = 2'b11;
      m_d1_prs = 2'b11; m_d2_prs = 2'b11; m_d1_int = 2'b11; m_d2_int = 2'b11;
      m_prs = 2'b11; m_int = 2'b11; m_int_old = 2'b11;
      for (int p = 0; p < 2; p++) begin
        m_run_prs[p] = 0; m_run_int[p] = 0; m_t0[p] = 0;
      end
      m_irq = 2'b00; m_irq_any = 1'b0;
      m_resetl = 2'b00; m_lpmode = 2'b11; m_modsell = 2'b11;
    end else begin
      m_irq_any = |m_irq;
      for (int p = 0; p < 2; p++) m_old_ph[p] = phase(p);
      m_cyc = m_cyc + 1;
      for (int p = 0; p < 2; p++) begin
        m_set  = 1'b0;
        m_fall = m_int_old[p] && !m_int[p];
        if (m_prs[p]) begin
          if (m_old_ph[p] == 3) m_set = 1'b1;
          m_absent[p] = 1'b1;
        end else if (m_absent[p] || sw_reset[p]) begin
          m_absent[p] = 1'b0;
          m_t0[p] = m_cyc;
        end
        if (m_old_ph[p] == 3 && m_fall) m_set = 1'b1;
        m_irq[p] = m_set | (m_irq[p] & ~irq_clear[p]);
        m_new_ph = phase(p);
        m_resetl[p]  = (m_new_ph >= 2);
        m_lpmode[p]  = (m_new_ph == 3) ? sw_lpmode[p] : 1'b1;
        m_modsell[p] = !((m_new_ph == 3) && iic_sel_en && (int'(iic_sel) == p));
      end
      m_int_old = m_int;
      // A pin value is accepted once it has disagreed for DB consecutive cycles.
      for (int p = 0; p < 2; p++) begin
        if (m_d2_prs[p] != m_prs[p]) m_run_prs[p]++; else m_run_prs[p] = 0;
        if (m_run_prs[p] == DB) begin m_prs[p] = m_d2_prs[p]; m_run_prs[p] = 0; end
        if (m_d2_int[p] != m_int[p]) m_run_int[p]++; else m_run_int[p] = 0;
        if (m_run_int[p] == DB) begin m_int[p] = m_d2_int[p]; m_run_int[p] = 0; end
      end
      m_d2_prs = m_d1_prs; m_d1_prs = modprsl;
      m_d2_int = m_d1_int; m_d1_int = intl;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    #1 resetn = 1'b0;
    tick();
    tick();
    checks++; if (qsfp_resetl !== 2'b00) begin errors++; $display("FAIL rst_resetl: got %b want 00", qsfp_resetl); end
    checks++; if (qsfp_lpmode !== 2'b11) begin errors++; $display("FAIL rst_lpmode: got %b want 11", qsfp_lpmode); end
    checks++; if (qsfp_modsell !== 2'b11) begin errors++; $display("FAIL rst_modsell: got %b want 11", qsfp_modsell); end
    checks++; if (port_state !== 4'h0) begin errors++; $display("FAIL rst_state: got %h want 0", port_state); end
    checks++; if (port_ready !== 2'b00 || irq !== 2'b00 || irq_any !== 1'b0) begin
      errors++; $display("FAIL rst_flags: ready=%b irq=%b irq_any=%b want all 0", port_ready, irq, irq_any);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_insertion();
    int low_cnt;
    sw_lpmode = 2'b00;
    modprsl[0] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (port_state[1:0] !== 2'd0) begin errors++; $display("FAIL ins_c6_state: got %0d want 0", port_state[1:0]); end
    tick();
    checks++; if (port_state[1:0] !== 2'd1) begin errors++; $display("FAIL ins_c7_state: got %0d want 1", port_state[1:0]); end
    low_cnt = 0;
    for (int i = 0; i < 40 && port_state[1:0] == 2'd1; i++) begin
      if (qsfp_resetl[0] === 1'b0) low_cnt++;
      tick();
    end
    checks++; if (low_cnt != RC) begin errors++; $display("FAIL ins_reset_len: got %0d want %0d", low_cnt, RC); end
    checks++; if (port_state[1:0] !== 2'd2 || qsfp_resetl[0] !== 1'b1) begin
      errors++; $display("FAIL ins_c15_init: state=%0d resetl=%b want 2/1", port_state[1:0], qsfp_resetl[0]);
    end
    for (int i = 0; i < 15; i++) tick();
    checks++; if (port_state[1:0] !== 2'd2 || qsfp_lpmode[0] !== 1'b1) begin
      errors++; $display("FAIL ins_c30: state=%0d lpmode=%b want 2/1", port_state[1:0], qsfp_lpmode[0]);
    end
    tick();
    checks++; if (port_state[1:0] !== 2'd3 || port_ready[0] !== 1'b1 || qsfp_lpmode[0] !== 1'b0) begin
      errors++; $display("FAIL ins_c31_ready: state=%0d ready=%b lpmode=%b want 3/1/0", port_state[1:0], port_ready[0], qsfp_lpmode[0]);
    end
  endtask

  task automatic test_glitch();
    modprsl[1] = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    modprsl[1] = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++; if (port_state[3:2] !== 2'd0 || qsfp_resetl[1] !== 1'b0) begin
        errors++; $display("FAIL glitch_c%0d: state=%0d resetl=%b want 0/0", i, port_state[3:2], qsfp_resetl[1]);
      end
    end
  endtask

  task automatic test_removal_init();
    sw_reset[0] = 1'b1;
    tick();
    sw_reset[0] = 1'b0;
    checks++; if (port_state[1:0] !== 2'd1) begin errors++; $display("FAIL rmi_swreset: got %0d want 1", port_state[1:0]); end
    for (int i = 0; i < 20 && port_state[1:0] != 2'd2; i++) tick();
    modprsl[0] = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (port_state[1:0] !== 2'd2) begin errors++; $display("FAIL rmi_still_init: got %0d want 2", port_state[1:0]); end
    sw_reset[0] = 1'b1;
    tick();
    sw_reset[0] = 1'b0;
    checks++; if (port_state[1:0] !== 2'd0 || qsfp_resetl[0] !== 1'b0 || qsfp_lpmode[0] !== 1'b1 || irq[0] !== 1'b0) begin
      errors++; $display("FAIL rmi_absent: state=%0d resetl=%b lpmode=%b irq=%b want 0/0/1/0",
                         port_state[1:0], qsfp_resetl[0], qsfp_lpmode[0], irq[0]);
    end
  endtask

  task automatic test_removal_ready();
    modprsl = 2'b00;
    for (int i = 0; i < 80 && port_ready !== 2'b11; i++) tick();
    checks++; if (port_ready !== 2'b11) begin errors++; $display("FAIL rmr_ready: got %b want 11", port_ready); end
    iic_sel = 1'b0; iic_sel_en = 1'b1;
    tick();
    checks++; if (qsfp_modsell !== 2'b10) begin errors++; $display("FAIL rmr_sel0: got %b want 10", qsfp_modsell); end
    iic_sel = 1'b1;
    tick();
    checks++; if (qsfp_modsell !== 2'b01) begin errors++; $display("FAIL rmr_sel1: got %b want 01", qsfp_modsell); end
    iic_sel = 1'b0;
    tick();
    modprsl[0] = 1'b1;
    for (int i = 0; i < 20 && port_state[1:0] == 2'd3; i++) tick();
    checks++; if (port_state[1:0] !== 2'd0 || qsfp_modsell !== 2'b11 || irq[0] !== 1'b1 || irq_any !== 1'b0) begin
      errors++; $display("FAIL rmr_leave: state=%0d modsell=%b irq=%b irq_any=%b want 0/11/1/0",
                         port_state[1:0], qsfp_modsell, irq[0], irq_any);
    end
    tick();
    checks++; if (irq_any !== 1'b1) begin errors++; $display("FAIL rmr_irq_any: got %b want 1", irq_any); end
    irq_clear[0] = 1'b1;
    tick();
    irq_clear[0] = 1'b0;
    checks++; if (irq[0] !== 1'b0) begin errors++; $display("FAIL rmr_clear: got %b want 0", irq[0]); end
    iic_sel_en = 1'b0;
    tick();
  endtask

  task automatic test_interrupt();
    modprsl[0] = 1'b0;
    for (int i = 0; i < 80 && port_ready !== 2'b11; i++) tick();
    checks++; if (port_ready !== 2'b11) begin errors++; $display("FAIL int_ready: got %b want 11", port_ready); end
    intl[1] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    intl[1] = 1'b1;
    checks++; if (irq[1] !== 1'b0) begin errors++; $display("FAIL int_early: got %b want 0", irq[1]); end
    tick();
    checks++; if (irq[1] !== 1'b1) begin errors++; $display("FAIL int_set: got %b want 1", irq[1]); end
    for (int i = 0; i < 10; i++) tick();
    intl[1] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    irq_clear[1] = 1'b1;
    tick();
    irq_clear[1] = 1'b0;
    checks++; if (irq[1] !== 1'b1) begin errors++; $display("FAIL int_set_wins: got %b want 1", irq[1]); end
    irq_clear[1] = 1'b1;
    tick();
    irq_clear[1] = 1'b0;
    checks++; if (irq[1] !== 1'b0) begin errors++; $display("FAIL int_clear: got %b want 0", irq[1]); end
    intl[1] = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (irq[1] !== 1'b0) begin errors++; $display("FAIL int_rise: got %b want 0", irq[1]); end
  endtask

  task automatic test_async_reset();
    int low_cnt;
    sw_reset[0] = 1'b1;
    tick();
    sw_reset[0] = 1'b0;
    tick();
    checks++; if (port_state[1:0] !== 2'd1) begin errors++; $display("FAIL ar_in_reset: got %0d want 1", port_state[1:0]); end
    #2 resetn = 1'b0;
    #1;
    checks++; if (qsfp_resetl !== 2'b00 || qsfp_lpmode !== 2'b11 || qsfp_modsell !== 2'b11 ||
                  port_state !== 4'h0 || port_ready !== 2'b00 || irq !== 2'b00 || irq_any !== 1'b0) begin
      errors++; $display("FAIL ar_immediate: resetl=%b lpmode=%b modsell=%b state=%h ready=%b irq=%b any=%b",
                         qsfp_resetl, qsfp_lpmode, qsfp_modsell, port_state, port_ready, irq, irq_any);
    end
    @(negedge clock);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (port_state[1:0] !== 2'd0) begin errors++; $display("FAIL ar_c6: got %0d want 0", port_state[1:0]); end
    tick();
    checks++; if (port_state[1:0] !== 2'd1) begin errors++; $display("FAIL ar_c7: got %0d want 1", port_state[1:0]); end
    low_cnt = 0;
    for (int i = 0; i < 40 && port_state[1:0] == 2'd1; i++) begin
      if (qsfp_resetl[0] === 1'b0) low_cnt++;
      tick();
    end
    checks++; if (low_cnt != RC || port_state[1:0] !== 2'd2) begin
      errors++; $display("FAIL ar_pulse: low=%0d state=%0d want %0d/2", low_cnt, port_state[1:0], RC);
    end
  endtask

  task automatic test_random();
    int prs_hold [2];
    int int_hold [2];
    logic [3:0] exp_state;
    logic [1:0] exp_ready;
    for (int p = 0; p < 2; p++) begin prs_hold[p] = 40; int_hold[p] = 5; end
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < 2; p++) begin
        exp_state[2*p +: 2] = 2'(phase(p));
        exp_ready[p] = (phase(p) == 3);
      end
      checks++; if (port_state !== exp_state) begin errors++; $display("FAIL rnd_state@%0d: got %h want %h", c, port_state, exp_state); end
      checks++; if (port_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready@%0d: got %b want %b", c, port_ready, exp_ready); end
      checks++; if (qsfp_resetl !== m_resetl) begin errors++; $display("FAIL rnd_resetl@%0d: got %b want %b", c, qsfp_resetl, m_resetl); end
      checks++; if (qsfp_lpmode !== m_lpmode) begin errors++; $display("FAIL rnd_lpmode@%0d: got %b want %b", c, qsfp_lpmode, m_lpmode); end
      checks++; if (qsfp_modsell !== m_modsell) begin errors++; $display("FAIL rnd_modsell@%0d: got %b want %b", c, qsfp_modsell, m_modsell); end
      checks++; if (qsfp_modsell === 2'b00) begin errors++; $display("FAIL rnd_onesel@%0d: got %b want at most one low", c, qsfp_modsell); end
      checks++; if (irq !== m_irq) begin errors++; $display("FAIL rnd_irq@%0d: got %b want %b", c, irq, m_irq); end
      checks++; if (irq_any !== m_irq_any) begin errors++; $display("FAIL rnd_irq_any@%0d: got %b want %b", c, irq_any, m_irq_any); end
      for (int p = 0; p < 2; p++) begin
        if (prs_hold[p] == 0) begin
          modprsl[p] = ~modprsl[p];
          prs_hold[p] = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : int'($urandom_range(20, 90));
        end else begin
          prs_hold[p]--;
        end
        if (int_hold[p] == 0) begin
          intl[p] = ~intl[p];
          int_hold[p] = int'($urandom_range(1, 12));
        end else begin
          int_hold[p]--;
        end
        sw_reset[p]  = ($urandom_range(0, 49) == 0);
        irq_clear[p] = ($urandom_range(0, 9) == 0);
      end
      sw_lpmode  = 2'($urandom_range(0, 3));
      iic_sel    = 1'($urandom_range(0, 1));
      iic_sel_en = ($urandom_range(0, 3) != 0);
      tick();
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    test_reset();
    test_insertion();
    test_glitch();
    test_removal_init();
    test_removal_ready();
    test_interrupt();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
